// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, start/stop validation, LSB-first deserialisation,
// valid/ready byte output with frame-error and overrun pulses.
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    samp_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;

    assign tick = (tick_cnt == TW'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments only; where two assignments to
    // the same register occur in one pass, the later one (state-specific) wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            tick_cnt  <= '0;
            samp_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Held at zero while idle so the first tick lands DIV clocks after START entry.
            if (state == IDLE || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);

            if (tick)
                samp_cnt <= samp_cnt + 4'd1;

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        busy     <= 1'b1;
                        samp_cnt <= '0;
                    end
                end
                START: begin
                    if (tick && samp_cnt == 4'd7) begin
                        samp_cnt <= '0;
                        bit_idx  <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick && samp_cnt == 4'd15) begin
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        samp_cnt       <= '0;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (tick && samp_cnt == 4'd15) begin
                        samp_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            // A pending unaccepted byte wins; the new one is dropped.
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            state     <= WAIT_IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        samp_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=4: directed frames plus randomized byte streams,
// checked against a frame-level reference of what the line carried.
module tb_uart_rx;

    localparam int DIV = 4;
    localparam int BIT = DIV * 16;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Monitor state
    byte_q_t got;
    int      rises[$];
    int      starts[$];
    int      fe_cnt = 0;
    int      ov_cnt = 0;
    int      vhi_cnt = 0;
    logic    prev_valid = 1'b0;

    uart_rx #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (rx_valid && !prev_valid) rises.push_back(cyc);
            if (rx_valid) vhi_cnt++;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            prev_valid = rx_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Line frame built from the byte: start 0, data LSB first, stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            if (i == 0) starts.push_back(cyc);
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic expect_bytes(input string tag, input int base, input byte_q_t exp);
        check({tag, "_count"}, got.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (base + i < got.size())
                check($sformatf("%s_byte%0d", tag, i), got[base + i], exp[i]);
    endtask

    initial begin
        int      gbase;
        int      fbase;
        int      obase;
        int      rbase;
        int      sbase;
        int      vbase;
        int      bsy;
        int      lat;
        byte_q_t exp;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single byte: content, latency, pulse width
        gbase = got.size(); fbase = fe_cnt; obase = ov_cnt;
        rbase = rises.size(); sbase = starts.size(); vbase = vhi_cnt;
        send_byte(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        exp = '{8'hA5};
        expect_bytes("a5", gbase, exp);
        check("a5_rises", rises.size() - rbase, 1);
        if (rises.size() > rbase) begin
            lat = rises[rbase] - starts[sbase];
            $display("info: start-to-valid latency %0d clocks", lat);
            check("a5_latency_611pm1", int'(lat >= 610 && lat <= 612), 1);
        end
        check("a5_valid_width", vhi_cnt - vbase, 1);
        check("a5_no_frame_err", fe_cnt - fbase, 0);
        check("a5_no_overrun", ov_cnt - obase, 0);

        // Back-to-back frames, one stop bit each
        gbase = got.size(); rbase = rises.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        exp = '{8'h00, 8'hFF, 8'h55};
        expect_bytes("b2b", gbase, exp);
        check("b2b_rises", rises.size() - rbase, 3);
        if (rises.size() >= rbase + 3) begin
            check("b2b_space1", rises[rbase + 1] - rises[rbase], 10 * BIT);
            check("b2b_space2", rises[rbase + 2] - rises[rbase + 1], 10 * BIT);
        end

        // 20-clock low glitch on an idle line
        gbase = got.size(); bsy = 0;
        rx = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 20) rx = 1'b1;
            @(negedge clk);
            if (busy) bsy++;
        end
        check("glitch_busy_seen", int'(bsy > 0), 1);
        check("glitch_busy_le40", int'(bsy <= 40), 1);
        check("glitch_busy_end", busy, 1'b0);
        check("glitch_no_byte", got.size() - gbase, 0);
        check("glitch_valid", rx_valid, 1'b0);

        // Stop bit low, line held low a further 200 clocks
        gbase = got.size(); fbase = fe_cnt;
        send_byte(8'h3C, 1'b0);
        repeat (200) @(negedge clk);
        check("ferr_busy_held", busy, 1'b1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("ferr_pulses", fe_cnt - fbase, 1);
        check("ferr_busy_released", busy, 1'b0);
        check("ferr_no_byte", got.size() - gbase, 0);
        check("ferr_valid", rx_valid, 1'b0);
        repeat (BIT) @(negedge clk);

        // Overrun with consumer stalled
        gbase = got.size(); obase = ov_cnt;
        rx_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        check("ovr_valid_held", rx_valid, 1'b1);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_pulses", ov_cnt - obase, 1);
        check("ovr_no_accept", got.size() - gbase, 0);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_valid_drop", rx_valid, 1'b0);
        check("ovr_data_after", rx_data, 8'h11);
        @(negedge clk);
        exp = '{8'h11};
        expect_bytes("ovr", gbase, exp);

        // Reset during bit 4 of 0x81, then a clean 0x7E
        begin
            logic [9:0] frame;
            frame = {1'b1, 8'h81, 1'b0};
            for (int i = 0; i < 6; i++) begin
                rx = frame[i];
                repeat ((i == 5) ? BIT / 2 : BIT) @(negedge clk);
            end
        end
        rst = 1'b1;
        rx = 1'b1;
        #1;
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ferr", frame_err, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        gbase = got.size(); fbase = fe_cnt;
        repeat (100) @(negedge clk);
        send_byte(8'h7E, 1'b1);
        repeat (20) @(negedge clk);
        exp = '{8'h7E};
        expect_bytes("post_rst", gbase, exp);
        check("post_rst_no_ferr", fe_cnt - fbase, 0);

        // Random bytes with random idle gaps (zero gap = back-to-back)
        gbase = got.size(); fbase = fe_cnt; obase = ov_cnt;
        exp = {};
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp.push_back(b);
            send_byte(b, 1'b1);
            repeat ($urandom_range(0, 100)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        expect_bytes("rand", gbase, exp);
        check("rand_no_ferr", fe_cnt - fbase, 0);
        check("rand_no_ovr", ov_cnt - obase, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
